// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 interrupt controller.
package sm83_pkg;

  // Interrupt sources; the enum value is also the IF/IE bit and the priority rank.
  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_src_e;

  // Dispatch sequencer states; D0..D4 are the five M-cycles of an interrupt entry.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D0   = 3'd1,
    ST_D1   = 3'd2,
    ST_D2   = 3'd3,
    ST_D3   = 3'd4,
    ST_D4   = 3'd5
  } irq_state_e;

  localparam logic [15:0] ADDR_IF  = 16'hFF0F;
  localparam logic [15:0] ADDR_IE  = 16'hFFFF;
  localparam logic [15:0] VEC_BASE = 16'h0040;

endpackage

// File: rtl/sm83_irq_prio.sv
// Lowest-set-bit priority encoder: bit 0 is the most urgent source.
module sm83_irq_prio #(
  parameter int unsigned N     = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sm83_irq_ctl.sv
// SM83 interrupt/halt sequencer: IE/IF registers, IME, HALT and the 5-M-cycle dispatch.
module sm83_irq_ctl #(
  parameter int unsigned N_IRQ    = 5,
  parameter logic [15:0] VEC_BASE = sm83_pkg::VEC_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m_tick,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic             instr_boundary,
  input  logic             op_ei,
  input  logic             op_di,
  input  logic             op_reti,
  input  logic             op_halt,
  input  logic             reg_we,
  input  logic             reg_sel,
  input  logic [7:0]       reg_wdata,
  output logic [7:0]       reg_rdata,
  output logic             ime,
  output logic             halted,
  output logic             halt_bug,
  output logic             disp_active,
  output logic [2:0]       disp_step,
  output logic             push_hi,
  output logic             push_lo,
  output logic             load_vec,
  output logic [15:0]      vector
);

  import sm83_pkg::*;

  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [7:0]       ie_q;
  logic [N_IRQ-1:0] if_q;
  logic [N_IRQ-1:0] if_d;
  logic             ime_q;
  logic             ei_pend_q;
  logic             halted_q;
  logic             halt_bug_q;
  irq_state_e       state_q;
  logic [2:0]       step_q;
  logic             active_q;
  logic             push_hi_q;
  logic             push_lo_q;
  logic             load_vec_q;
  logic [15:0]      vector_q;

  logic             ie_wr;
  logic             if_wr;
  logic [N_IRQ-1:0] pending;
  logic             any_pending;
  logic [7:0]       ie_eff;
  logic [N_IRQ-1:0] resolve_pending;
  logic             resolve;
  logic             dispatch_go;
  logic             prio_valid;
  logic [IDX_W-1:0] prio_idx;
  logic [N_IRQ-1:0] clr_mask;

  assign ie_wr       = m_tick & reg_we & reg_sel;
  assign if_wr       = m_tick & reg_we & ~reg_sel;
  assign pending     = ie_q[N_IRQ-1:0] & if_q;
  assign any_pending = |pending;

  // The high-byte push can land on IE in the very M-cycle that resolves priority,
  // so the resolver sees the value being written this tick rather than the stale one.
  assign ie_eff          = ie_wr ? reg_wdata : ie_q;
  assign resolve_pending = ie_eff[N_IRQ-1:0] & if_q;
  assign resolve         = m_tick & (state_q == ST_D2);
  assign dispatch_go     = m_tick & (state_q == ST_IDLE) & instr_boundary & ime_q & any_pending;
  assign clr_mask        = (resolve & prio_valid) ? (N_IRQ'(1) << prio_idx) : '0;

  sm83_irq_prio #(
    .N     (N_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .req   (resolve_pending),
    .valid (prio_valid),
    .idx   (prio_idx)
  );

  // Next IF: acknowledge clear, then CPU write, then peripheral requests win per bit.
  always_comb begin
    if_d = if_q & ~clr_mask;
    if (if_wr) if_d = reg_wdata[N_IRQ-1:0];
    if_d = if_d | irq_req;
  end

  // IF samples requests every clk; IE only changes on CPU writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      if_q <= if_d;
      if (ie_wr) ie_q <= reg_wdata;
    end
  end

  // IME and the one-instruction EI delay; later rules override earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
    end else if (m_tick) begin
      if (ei_pend_q && instr_boundary) begin
        ime_q     <= 1'b1;
        ei_pend_q <= 1'b0;
      end
      if (op_reti) ime_q <= 1'b1;
      if (op_ei) ei_pend_q <= 1'b1;
      if (op_di) begin
        ime_q     <= 1'b0;
        ei_pend_q <= 1'b0;
      end
      if (dispatch_go) ime_q <= 1'b0;
    end
  end

  // HALT entry on m_tick, wake on any clk with a pending source, and the HALT bug pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q   <= 1'b0;
      halt_bug_q <= 1'b0;
    end else begin
      if (halted_q && any_pending) halted_q <= 1'b0;
      else if (m_tick && op_halt && !halted_q && (ime_q || !any_pending)) halted_q <= 1'b1;
      if (m_tick) halt_bug_q <= op_halt & ~ime_q & any_pending;
    end
  end

  // Dispatch sequencer with registered step strobes and the latched vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      active_q   <= 1'b0;
      push_hi_q  <= 1'b0;
      push_lo_q  <= 1'b0;
      load_vec_q <= 1'b0;
      vector_q   <= 16'h0000;
    end else if (m_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (dispatch_go) begin
            state_q  <= ST_D0;
            step_q   <= 3'd0;
            active_q <= 1'b1;
          end
        end
        ST_D0: begin
          state_q <= ST_D1;
          step_q  <= 3'd1;
        end
        ST_D1: begin
          state_q   <= ST_D2;
          step_q    <= 3'd2;
          push_hi_q <= 1'b1;
        end
        ST_D2: begin
          state_q   <= ST_D3;
          step_q    <= 3'd3;
          push_hi_q <= 1'b0;
          push_lo_q <= 1'b1;
          vector_q  <= prio_valid ? (VEC_BASE + (16'(prio_idx) << 3)) : 16'h0000;
        end
        ST_D3: begin
          state_q    <= ST_D4;
          step_q     <= 3'd4;
          push_lo_q  <= 1'b0;
          load_vec_q <= 1'b1;
        end
        ST_D4: begin
          state_q    <= ST_IDLE;
          step_q     <= 3'd0;
          load_vec_q <= 1'b0;
          active_q   <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          step_q     <= 3'd0;
          active_q   <= 1'b0;
          push_hi_q  <= 1'b0;
          push_lo_q  <= 1'b0;
          load_vec_q <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; unimplemented IF bits read as ones.
  always_comb begin
    reg_rdata = 8'hFF;
    if (reg_sel) reg_rdata = ie_q;
    else reg_rdata[N_IRQ-1:0] = if_q;
  end

  assign ime         = ime_q;
  assign halted      = halted_q;
  assign halt_bug    = halt_bug_q;
  assign disp_active = active_q;
  assign disp_step   = step_q;
  assign push_hi     = push_hi_q;
  assign push_lo     = push_lo_q;
  assign load_vec    = load_vec_q;
  assign vector      = vector_q;

endmodule

// File: doc/sm83_irq_ctl.md
Name: sm83_irq_ctl

Overview:
Interrupt and halt sequencer for the SM83 core. It owns the IE/IF registers and the IME flag, applies EI/DI/RETI/HALT semantics, and decides at each instruction boundary whether the core fetches normally or runs the 5-M-cycle interrupt dispatch. It sits beside the decode stage: the decoder's CTL_EI/CTL_DI/CTL_RETI/CTL_HALT results drive it, and its dispatch outputs steer the PC/SP datapath.

Parameters:
N_IRQ, 5, number of interrupt sources (VBlank, STAT, Timer, Serial, Joypad; bit 0 = highest priority)
VEC_BASE, 16'h0040, vector of source 0; source i vectors to VEC_BASE + 8*i

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
m_tick  in  1  one-clk strobe marking the end of an M-cycle; all architectural state advances only on m_tick
irq_req  in  N_IRQ  peripheral request pulses, sampled on every clk
instr_boundary  in  1  core is at the opcode-fetch M-cycle of the next instruction
op_ei  in  1  EI executed (valid with m_tick)
op_di  in  1  DI executed
op_reti  in  1  RETI executed
op_halt  in  1  HALT executed
reg_we  in  1  CPU write to IE/IF
reg_sel  in  1  0 = IF (FF0F), 1 = IE (FFFF)
reg_wdata  in  8  write data
reg_rdata  out  8  read data for reg_sel
ime  out  1  interrupt master enable
halted  out  1  core is stalled in HALT
halt_bug  out  1  one-M-cycle pulse: next opcode fetch must not increment PC
disp_active  out  1  dispatch in progress; core suppresses fetch
disp_step  out  3  dispatch step index 0..4
push_hi  out  1  step 2: core pushes PC[15:8], SP decremented
push_lo  out  1  step 3: core pushes PC[7:0], SP decremented
load_vec  out  1  step 4: core loads PC <= vector
vector  out  16  dispatch target, valid while load_vec is high

Behaviour:
- Reset: IE=0, IF=0, ime=0, halted=0, ei_pend=0, state IDLE. All strobes low, vector=0, reg_rdata reflects the reset registers.
- IF: irq_req[i] sets IF[i] on any clk. A CPU write loads IF[N_IRQ-1:0]. When a write and a request coincide, the request wins per bit. Reads return {3'b111, IF[4:0]}. IE is a full 8-bit register that reads back as written.
- pending = IE[4:0] & IF[4:0].
- IME rules, evaluated on m_tick:
  - DI clears ime and ei_pend.
  - EI sets ei_pend. ime becomes 1 on the m_tick of the next instr_boundary after EI. A second EI has no additional effect.
  - RETI sets ime immediately.
  - Dispatch entry clears ime.
- HALT:
  - op_halt with ime=1, or with pending=0, sets halted=1.
  - op_halt with ime=0 and pending!=0 does not halt. halt_bug pulses for one M-cycle.
  - While halted, wake on the first clk where pending!=0, independent of IME. Wake clears halted. If ime=1, dispatch starts at the next boundary.
- FSM states: IDLE, D0, D1, D2(push_hi), D3(push_lo), D4(load_vec). Transitions occur on m_tick only.
  - IDLE->D0 when instr_boundary & ime & pending!=0. EI-delay ime=0 blocks this. ime clears at D0 entry.
  - D0->D1->D2->D3->D4->IDLE, one M-cycle each. disp_active=1 in D0..D4.
  - Priority is resolved on the m_tick ending D2, after the high-byte push, so a push that overwrites IE takes effect. The lowest pending index i is latched: vector=VEC_BASE+8*i, and IF[i] is cleared on that same m_tick.
  - If pending=0 at that point (cancelled dispatch), vector=16'h0000 and IF is unchanged.
- An irq_req arriving during dispatch only sets IF. The same source can re-dispatch after the handler re-enables IME.
- An asynchronous reset mid-dispatch returns to IDLE immediately. Strobes drop with no further pushes.

Decomposition:
- Package sm83_pkg: irq_src_e (IRQ_VBLANK..IRQ_JOYPAD), irq_state_e, localparams ADDR_IF/ADDR_IE and VEC_BASE.
- Sub-module sm83_irq_prio: combinational lowest-set-bit priority encoder producing a valid flag and index.

Test Plan:
1. Reset, then read IF -> 8'hE0; read IE -> 8'h00; ime=0, disp_active=0.
2. IE=8'h05, ime=1, irq_req=5'b00100 (timer) at boundary -> D0..D4 over 5 m_ticks; push_hi in step 2, push_lo in step 3; vector=16'h0050; IF[2] cleared; ime=0.
3. Simultaneous irq_req=5'b00011 with IE=8'h1F -> vector=16'h0040; IF afterwards 8'hE2.
4. EI, then pending timer at the very next boundary -> no dispatch there; dispatch starts at the following boundary. EI immediately followed by DI -> never dispatches.
5. ime=0, IE=8'h01, IF=8'h01, op_halt -> halted stays 0 and halt_bug pulses for 1 M-cycle. Same case with IF=0 -> halted=1; irq_req[0] -> halted=0 with no dispatch.
6. Dispatch with a CPU IE write of 8'h00 landing during D2 -> vector=16'h0000 and IF unchanged. Separately, drop rst_n during D3 -> next clk is IDLE with all strobes 0.
